// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with a one-entry output
// register and redirect support (in-flight data is dropped after a redirect).
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INCR  = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);
   typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DISCARD = 2'd2} state_t;
   state_t      r_state;
   logic [31:0] r_pc, r_addr, r_inst, r_inst_pc;
   logic        r_valid;
   logic [31:0] w_rpc, w_next;
   assign w_rpc  = redirect_pc & ~32'h3;
   assign w_next = (r_pc + PC_INCR) & ~32'h3;
   // DISCARD keeps presenting the abandoned address until its ack arrives
   assign imem_req   = ~reset & (r_state != HOLD);
   assign imem_addr  = (r_state == DISCARD) ? r_addr : r_pc;
   assign inst_valid = r_valid;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= FETCH;
         r_pc      <= RESET_PC & ~32'h3;
         r_addr    <= '0;
         r_valid   <= 1'b0;
         r_inst    <= '0;
         r_inst_pc <= '0;
      end else begin
         case (r_state)
            FETCH:
               if (redirect) begin
                  r_pc    <= w_rpc;
                  r_addr  <= r_pc;
                  r_state <= imem_ack ? FETCH : DISCARD;
               end else if (imem_ack) begin
                  r_inst    <= imem_rdata;
                  r_inst_pc <= r_pc;
                  r_valid   <= 1'b1;
                  r_pc      <= w_next;
                  r_state   <= HOLD;
               end
            HOLD:
               if (redirect) begin
                  r_valid <= 1'b0;
                  r_pc    <= w_rpc;
                  r_state <= FETCH;
               end else if (inst_ready) begin
                  r_valid <= 1'b0;
                  r_state <= FETCH;
               end
            DISCARD: begin
               if (redirect) r_pc <= w_rpc;
               if (imem_ack) r_state <= FETCH;
            end
            default: r_state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors with hand-computed expectations for fetch_unit.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req, imem_ack = 1'b0, redirect = 1'b0, inst_valid, inst_ready = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, inst, inst_pc;
   int          n_tests = 0, n_fail = 0;

   typedef struct {
      logic        rst, ack;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_val;
      logic [31:0] e_inst, e_ipc;
   } vec_t;

   vec_t main_v[$];
   vec_t hand_v[$];

   fetch_unit #(.RESET_PC(32'h0), .PC_INCR(32'd4)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
      .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic redir,
                               logic [31:0] rpc, logic rdy, logic e_req, logic [31:0] e_addr,
                               logic e_val, logic [31:0] e_inst, logic [31:0] e_ipc);
      vec_t v;
      v.rst = rst; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_inst = e_inst; v.e_ipc = e_ipc;
      return v;
   endfunction

   // inputs are applied after the falling edge, outputs checked 1ns later, state moves at the next rising edge
   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      reset = v.rst; imem_ack = v.ack; imem_rdata = v.rdata;
      redirect = v.redir; redirect_pc = v.rpc; inst_ready = v.rdy;
      #1;
      n_tests++;
      if (imem_req !== v.e_req || imem_addr !== v.e_addr || inst_valid !== v.e_val ||
          inst !== v.e_inst || inst_pc !== v.e_ipc) begin
         n_fail++;
         $display("FAIL %s: got req=%0b addr=%h val=%0b inst=%h pc=%h, want req=%0b addr=%h val=%0b inst=%h pc=%h",
                  name, imem_req, imem_addr, inst_valid, inst, inst_pc,
                  v.e_req, v.e_addr, v.e_val, v.e_inst, v.e_ipc);
      end
   endtask

   initial begin
      //                 rst ack rdata         redir rpc           rdy  req addr          val inst          ipc
      main_v.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          32'h0));
      main_v.push_back(mk(0, 1, 32'hA000_0000,  0, 32'h0,          1,   1, 32'h0,          0, 32'h0,          32'h0));
      main_v.push_back(mk(0, 1, 32'hDEAD_0000,  0, 32'h0,          1,   0, 32'h4,          1, 32'hA000_0000,  32'h0));
      main_v.push_back(mk(0, 1, 32'hA000_0004,  0, 32'h0,          1,   1, 32'h4,          0, 32'hA000_0000,  32'h0));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h8,          1, 32'hA000_0004,  32'h4));
      main_v.push_back(mk(0, 1, 32'hBAD0_0000,  0, 32'h0,          0,   0, 32'h8,          1, 32'hA000_0004,  32'h4));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h8,          1, 32'hA000_0004,  32'h4));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h8,          1, 32'hA000_0004,  32'h4));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h8,          1, 32'hA000_0004,  32'h4));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   0, 32'h8,          1, 32'hA000_0004,  32'h4));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8,          0, 32'hA000_0004,  32'h4));
      main_v.push_back(mk(0, 1, 32'hA000_0008,  0, 32'h0,          1,   1, 32'h8,          0, 32'hA000_0004,  32'h4));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   0, 32'hC,          1, 32'hA000_0008,  32'h8));
      main_v.push_back(mk(0, 0, 32'h0,          1, 32'h103,        1,   1, 32'hC,          0, 32'hA000_0008,  32'h8));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'hC,          0, 32'hA000_0008,  32'h8));
      main_v.push_back(mk(0, 1, 32'hBAD0_0010,  0, 32'h0,          1,   1, 32'hC,          0, 32'hA000_0008,  32'h8));
      main_v.push_back(mk(0, 1, 32'hB000_0100,  0, 32'h0,          0,   1, 32'h100,        0, 32'hA000_0008,  32'h8));
      main_v.push_back(mk(0, 0, 32'h0,          1, 32'h200,        1,   0, 32'h104,        1, 32'hB000_0100,  32'h100));
      main_v.push_back(mk(0, 1, 32'hBAD0_0020,  1, 32'h300,        0,   1, 32'h200,        0, 32'hB000_0100,  32'h100));
      main_v.push_back(mk(0, 0, 32'h0,          1, 32'h400,        0,   1, 32'h300,        0, 32'hB000_0100,  32'h100));
      main_v.push_back(mk(0, 0, 32'h0,          1, 32'h500,        0,   1, 32'h300,        0, 32'hB000_0100,  32'h100));
      main_v.push_back(mk(0, 1, 32'hBAD0_0300,  1, 32'h600,        0,   1, 32'h300,        0, 32'hB000_0100,  32'h100));
      main_v.push_back(mk(0, 1, 32'hC000_0600,  0, 32'h0,          0,   1, 32'h600,        0, 32'hB000_0100,  32'h100));
      main_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h604,        1, 32'hC000_0600,  32'h600));
      // wrap at the top of the address space, then reset while a request is being discarded
      hand_v.push_back(mk(0, 0, 32'h0,          1, 32'hFFFF_FFFF,  0,   0, 32'h604,        1, 32'hC000_0600,  32'h600));
      hand_v.push_back(mk(0, 1, 32'hD000_0000,  0, 32'h0,          0,   1, 32'hFFFF_FFFC,  0, 32'hC000_0600,  32'h600));
      hand_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   0, 32'h0,          1, 32'hD000_0000,  32'hFFFF_FFFC));
      hand_v.push_back(mk(0, 1, 32'hD000_0001,  0, 32'h0,          0,   1, 32'h0,          0, 32'hD000_0000,  32'hFFFF_FFFC));
      hand_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   0, 32'h4,          1, 32'hD000_0001,  32'h0));
      hand_v.push_back(mk(0, 0, 32'h0,          1, 32'h800,        0,   1, 32'h4,          0, 32'hD000_0001,  32'h0));
      hand_v.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0,   0, 32'h4,          0, 32'hD000_0001,  32'h0));
      hand_v.push_back(mk(1, 1, 32'hBAD0_0004,  0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          32'h0));
      hand_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          32'h0));
      hand_v.push_back(mk(0, 1, 32'hE000_0000,  0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          32'h0));
      hand_v.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h4,          1, 32'hE000_0000,  32'h0));

      repeat (2) @(posedge clk);
      foreach (main_v[i]) apply(main_v[i], $sformatf("vec%0d", i));
      foreach (hand_v[i]) apply(hand_v[i], $sformatf("seq%0d", i));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
